// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
//   Measures the high and low phase lengths of a divided clock (i_meas_clk)
//   in units of the reference clock, reports their sum as the period ratio,
//   flags lock when two consecutive periods agree, and flags a timeout when
//   an expected edge does not arrive within MAX = 2^DIV_WIDTH-1 cycles.
//
// Ports
//   i_ref_clk   in   reference clock, all logic on its rising edge
//   i_rst_n     in   asynchronous active-low reset
//   i_meas_en   in   measurement enable; low returns the meter to IDLE
//   i_meas_clk  in   clock under measurement, asynchronous to i_ref_clk
//   o_high_cnt  out  [DIV_WIDTH-1:0] last measured high-phase length
//   o_low_cnt   out  [DIV_WIDTH-1:0] last measured low-phase length
//   o_ratio     out  [DIV_WIDTH:0]   high + low of the last full period
//   o_valid     out  one-cycle pulse when o_ratio updates
//   o_locked    out  two consecutive periods produced the same ratio
//   o_timeout   out  no expected edge within MAX cycles (held until next valid)
module clk_ratio_meter #(
  parameter int unsigned DIV_WIDTH = 4
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  input  logic                 i_meas_en,
  input  logic                 i_meas_clk,
  output logic [DIV_WIDTH-1:0] o_high_cnt,
  output logic [DIV_WIDTH-1:0] o_low_cnt,
  output logic [DIV_WIDTH:0]   o_ratio,
  output logic                 o_valid,
  output logic                 o_locked,
  output logic                 o_timeout
);

  localparam logic [DIV_WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t               state;
  state_t               next_state;

  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic                 rise;
  logic                 fall;

  logic [DIV_WIDTH-1:0] counter;
  logic                 have_prev;

  logic                 edge_hit;
  logic                 tmo_hit;
  logic [DIV_WIDTH:0]   ratio_next;

  // Two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_meas_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign ratio_next = {1'b0, o_high_cnt} + {1'b0, counter};

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only the edge each state is waiting for counts; the opposite edge is
  // ignored and does not rescue the counter from timing out.
  always_comb begin
    next_state = state;
    edge_hit   = 1'b0;
    tmo_hit    = 1'b0;
    if (!i_meas_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = ARM;
        ARM: begin
          if (rise) begin
            edge_hit   = 1'b1;
            next_state = HIGH;
          end else if (counter == MAX) begin
            tmo_hit    = 1'b1;
            next_state = ARM;
          end
        end
        HIGH: begin
          if (fall) begin
            edge_hit   = 1'b1;
            next_state = LOW;
          end else if (counter == MAX) begin
            tmo_hit    = 1'b1;
            next_state = ARM;
          end
        end
        LOW: begin
          if (rise) begin
            edge_hit   = 1'b1;
            next_state = HIGH;
          end else if (counter == MAX) begin
            tmo_hit    = 1'b1;
            next_state = ARM;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      counter    <= '0;
      have_prev  <= 1'b0;
      o_high_cnt <= '0;
      o_low_cnt  <= '0;
      o_ratio    <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_meas_en || state == IDLE) begin
        counter   <= '0;
        have_prev <= 1'b0;
        o_locked  <= 1'b0;
        o_timeout <= 1'b0;
      end else if (tmo_hit) begin
        counter   <= '0;
        have_prev <= 1'b0;
        o_locked  <= 1'b0;
        o_timeout <= 1'b1;
      end else if (edge_hit) begin
        counter <= DIV_WIDTH'(1);
        if (state == HIGH) begin
          o_high_cnt <= counter;
        end else if (state == LOW) begin
          o_low_cnt <= counter;
          o_ratio   <= ratio_next;
          o_valid   <= 1'b1;
          o_locked  <= have_prev && (ratio_next == o_ratio);
          have_prev <= 1'b1;
          o_timeout <= 1'b0;
        end
      end else begin
        counter <= counter + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
module tb_clk_ratio_meter;

  logic       i_ref_clk;
  logic       i_rst_n;
  logic       i_meas_en;
  logic       i_meas_clk;
  logic [3:0] o_high_cnt;
  logic [3:0] o_low_cnt;
  logic [4:0] o_ratio;
  logic       o_valid;
  logic       o_locked;
  logic       o_timeout;

  clk_ratio_meter #(.DIV_WIDTH(4)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_meas_en  (i_meas_en),
    .i_meas_clk (i_meas_clk),
    .o_high_cnt (o_high_cnt),
    .o_low_cnt  (o_low_cnt),
    .o_ratio    (o_ratio),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_timeout  (o_timeout)
  );

  initial i_ref_clk = 1'b0;
  always #5 i_ref_clk = ~i_ref_clk;

  int cyc = 0;
  always @(posedge i_ref_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h;
    int l;
    int r;
    int lk;
    int t;
  } exp_t;

  exp_t sb[$];

  // Stimulus-side bookkeeping: phase 0 = not measuring, 1 = in high, 2 = in low
  int m_phase    = 0;
  int m_run_len  = 0;
  int m_h        = 0;
  int m_have_prev = 0;
  int m_ratio    = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_ref_clk);
      m_run_len++;
    end
  endtask

  task automatic model_clear(input int clr_ratio);
    m_phase     = 0;
    m_have_prev = 0;
    if (clr_ratio != 0) m_ratio = 0;
  endtask

  task automatic set_meas(input logic v);
    exp_t e;
    if (v && !i_meas_clk) begin
      if (m_phase == 2) begin
        e.h  = m_h;
        e.l  = m_run_len;
        e.r  = m_h + m_run_len;
        e.lk = (m_have_prev != 0 && e.r == m_ratio) ? 1 : 0;
        e.t  = cyc;
        m_have_prev = 1;
        m_ratio     = e.r;
        sb.push_back(e);
      end
      m_phase   = 1;
      m_run_len = 0;
    end else if (!v && i_meas_clk) begin
      if (m_phase == 1) begin
        m_h     = m_run_len;
        m_phase = 2;
      end
      m_run_len = 0;
    end
    i_meas_clk = v;
  endtask

  task automatic period(input int h, input int l);
    set_meas(1'b1);
    step(h);
    set_meas(1'b0);
    step(l);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high"},    o_high_cnt, 0);
    check({tag, "_low"},     o_low_cnt,  0);
    check({tag, "_ratio"},   o_ratio,    0);
    check({tag, "_valid"},   o_valid,    0);
    check({tag, "_locked"},  o_locked,   0);
    check({tag, "_timeout"}, o_timeout,  0);
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation
  always @(negedge i_ref_clk) begin
    exp_t e;
    int lat;
    if (i_rst_n && o_valid) begin
      if (sb.size() == 0) begin
        check("valid_unexpected", o_valid, 0);
      end else begin
        e = sb.pop_front();
        lat = cyc - e.t;
        check("high_cnt",   o_high_cnt, e.h);
        check("low_cnt",    o_low_cnt,  e.l);
        check("ratio",      o_ratio,    e.r);
        check("locked",     o_locked,   e.lk);
        check("timeout_v",  o_timeout,  0);
        check("latency_ok", (lat >= 3 && lat <= 4) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n    = 1'b0;
    i_meas_en  = 1'b0;
    i_meas_clk = 1'b0;
    #1;
    check_all_zero("reset");
    step(2);
    i_rst_n   = 1'b1;
    i_meas_en = 1'b1;
    step(4);

    // Divide by 4
    for (int i = 0; i < 6; i++) period(2, 2);
    // Ratio change to 6 mid-run
    for (int i = 0; i < 3; i++) period(3, 3);
    // Divide by 5
    for (int i = 0; i < 4; i++) period(2, 3);

    // Clock stuck low: timeout
    step(20);
    model_clear(0);
    check("stuck_low_timeout", o_timeout, 1);
    check("stuck_low_locked",  o_locked,  0);
    check("stuck_low_valid",   o_valid,   0);

    // Restart at divide by 4
    for (int i = 0; i < 4; i++) period(2, 2);

    // Enable dropped mid-HIGH
    set_meas(1'b1);
    step(4);
    i_meas_en = 1'b0;
    step(1);
    model_clear(0);
    check("en_drop_locked",  o_locked,  0);
    check("en_drop_valid",   o_valid,   0);
    check("en_drop_timeout", o_timeout, 0);
    check("en_drop_ratio",   o_ratio,   m_ratio);
    step(2);
    set_meas(1'b0);
    step(3);
    i_meas_en = 1'b1;
    step(3);
    for (int i = 0; i < 4; i++) period(2, 2);

    // Reset pulsed mid-LOW
    set_meas(1'b1);
    step(3);
    set_meas(1'b0);
    step(5);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_clear(1);
    step(1);
    i_rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 4; i++) period(2, 2);

    // Clock stuck high (divider bypass): timeout, no valid
    set_meas(1'b1);
    step(22);
    model_clear(0);
    check("stuck_high_timeout", o_timeout, 1);
    check("stuck_high_valid",   o_valid,   0);
    check("stuck_high_locked",  o_locked,  0);

    step(6);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
